// File: rtl/shift_add_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mac_pkg
//  Description : Shared definitions for the systolic-array MAC blocks: default
//                operand/accumulator widths and the MAC controller state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_add_mac_pkg;

  localparam int MAC_W_DEFAULT     = 8;
  localparam int MAC_ACC_W_DEFAULT = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mac_ctrl
//  Description : Sequencer for the shift-add MAC. Accepts a start in IDLE or
//                DONE, runs the datapath for one step per cycle until the
//                datapath reports its last step, then issues one accumulate
//                cycle and one done cycle.
//  Ports       : clk       - clock
//                clear     - synchronous active-high reset
//                start     - operation request
//                last_step - datapath step counter is at W-1
//                load      - capture operands this edge
//                run_en    - perform one shift-add step this edge
//                acc_en    - fold partial product into acc this edge
//                busy      - operation in progress (RUN/ACC/DONE)
//                done      - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_ctrl
  import shift_add_mac_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic start,
  input  logic last_step,
  output logic load,
  output logic run_en,
  output logic acc_en,
  output logic busy,
  output logic done
);

  mac_state_t state;
  mac_state_t next_state;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    run_en     = 1'b0;
    acc_en     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (last_step) begin
          next_state = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_en     = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        // A start seen while leaving DONE is taken directly, so that
        // operations can issue back-to-back without an IDLE bubble.
        if (start) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_add_mac.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mac
//  Description : Unsigned multiply-accumulate using a fixed-latency shift-add
//                multiplier (W RUN cycles), followed by an accumulate cycle
//                and a done cycle. Sticky overflow on accumulator carry-out.
//  Ports       : clk     - clock
//                clear   - synchronous active-high reset
//                start   - request one MAC operation
//                acc_clr - with start: 1 = replace acc, 0 = add to acc
//                mcand   - multiplicand (held stable by upstream while hold)
//                mplier  - multiplier, sampled with start
//                busy    - operation in progress
//                hold    - copy of busy for the upstream register
//                done    - one-cycle pulse, acc valid from this cycle on
//                acc     - accumulated result
//                ovf     - sticky accumulator overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mac
  import shift_add_mac_pkg::*;
#(
  parameter int W     = MAC_W_DEFAULT,
  parameter int ACC_W = MAC_ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             acc_clr,
  input  logic [W-1:0]     mcand,
  input  logic [W-1:0]     mplier,
  output logic             busy,
  output logic             hold,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] pp;
  logic [W-1:0]   sr;
  logic [SW-1:0]  step;
  logic           clr_lat;

  logic           load;
  logic           run_en;
  logic           acc_en;
  logic           last_step;
  logic [2*W-1:0] addend;
  logic [ACC_W:0] acc_sum;

  assign last_step = (step == SW'(W - 1));
  assign addend    = {{W{1'b0}}, mcand} << step;
  // One extra bit captures the carry out of the accumulator.
  assign acc_sum   = {1'b0, acc} + {1'b0, ACC_W'(pp)};
  assign hold      = busy;

  mac_ctrl u_ctrl (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .last_step (last_step),
    .load      (load),
    .run_en    (run_en),
    .acc_en    (acc_en),
    .busy      (busy),
    .done      (done)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      pp      <= '0;
      sr      <= '0;
      step    <= '0;
      clr_lat <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      if (load) begin
        sr      <= mplier;
        clr_lat <= acc_clr;
        pp      <= '0;
        step    <= '0;
        // A fresh accumulation restarts the overflow history.
        if (acc_clr) begin
          ovf <= 1'b0;
        end
      end
      if (run_en) begin
        if (sr[0]) begin
          pp <= pp + addend;
        end
        sr   <= sr >> 1;
        step <= step + SW'(1);
      end
      if (acc_en) begin
        if (clr_lat) begin
          acc <= ACC_W'(pp);
        end else begin
          acc <= acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W]) begin
            ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mac
//  Description : Self-checking bench for shift_add_mac (W=8/ACC_W=20 and a
//                W=8/ACC_W=16 instance for the overflow case).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mac;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: ACC_W = 20
  logic         clear, start, acc_clr;
  logic [W-1:0] mcand, mplier;
  logic         busy, hold, done, ovf;
  logic [19:0]  acc;

  // Instance B: ACC_W = 16
  logic         b_clear, b_start, b_acc_clr;
  logic [W-1:0] b_mcand, b_mplier;
  logic         b_busy, b_hold, b_done, b_ovf;
  logic [15:0]  b_acc;

  shift_add_mac #(.W(W), .ACC_W(20)) dut_a (
    .clk(clk), .clear(clear), .start(start), .acc_clr(acc_clr),
    .mcand(mcand), .mplier(mplier), .busy(busy), .hold(hold),
    .done(done), .acc(acc), .ovf(ovf)
  );

  shift_add_mac #(.W(W), .ACC_W(16)) dut_b (
    .clk(clk), .clear(b_clear), .start(b_start), .acc_clr(b_acc_clr),
    .mcand(b_mcand), .mplier(b_mplier), .busy(b_busy), .hold(b_hold),
    .done(b_done), .acc(b_acc), .ovf(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for instance A
  longint m_acc = 0;
  bit     m_ovf = 0;
  int     last_accept = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic void model_op(input int a, input int b, input bit c);
    longint s;
    if (c) begin
      m_acc = longint'(a) * b;
      m_ovf = 0;
    end else begin
      s = m_acc + longint'(a) * b;
      if (s >= (64'd1 << 20)) m_ovf = 1;
      m_acc = s % (64'd1 << 20);
    end
  endfunction

  // Issues one operation on A and waits for its done pulse; returns in the
  // done cycle so a following call issues back-to-back.
  task automatic issue(input int a, input int b, input bit c, input bit b2b, input bit spur, input string tag);
    int n;
    bit got;
    mcand = W'(a); mplier = W'(b); acc_clr = c; start = 1'b1;
    @(posedge clk); #1;
    if (b2b) check({tag, "_interval"}, cyc - last_accept, W + 2);
    last_accept = cyc;
    model_op(a, b, c);
    n = 0; got = 0;
    while (!got && n < 30) begin
      start = spur && (n < 7);
      @(posedge clk); #1;
      n++;
      if (n <= W && busy !== 1'b1) check({tag, "_busy_run"}, busy, 1);
      if (done) got = 1;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_acc"}, acc, 32'(m_acc));
    check({tag, "_ovf"}, ovf, m_ovf);
    check({tag, "_hold"}, hold, busy);
  endtask

  task automatic issue_b(input int a, input int b, input bit c, input int e_acc, input bit e_ovf, input string tag);
    int n;
    b_mcand = W'(a); b_mplier = W'(b); b_acc_clr = c; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_acc"}, b_acc, e_acc);
    check({tag, "_ovf"}, b_ovf, e_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; acc_clr = 1'b0; mcand = '0; mplier = '0;
    b_clear = 1'b1; b_start = 1'b0; b_acc_clr = 1'b0; b_mcand = '0; b_mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0; b_clear = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_hold", hold, 0);
    check("rst_done", done, 0);
    check("rst_acc", acc, 0);
    check("rst_ovf", ovf, 0);

    // Basic operation and full-scale operands
    issue(5, 3, 1, 0, 0, "basic");
    @(posedge clk); #1;
    check("basic_done_width", done, 0);
    check("basic_idle", busy, 0);
    issue(255, 255, 1, 0, 0, "max_clr");
    @(posedge clk); #1;
    issue(255, 255, 0, 0, 0, "max_add");
    @(posedge clk); #1;
    check("max_add_value", acc, 130050);

    // Back-to-back
    issue(2, 3, 1, 0, 0, "b2b0");
    issue(4, 5, 0, 1, 0, "b2b1");
    issue(6, 7, 0, 1, 0, "b2b2");
    check("b2b_final", acc, 68);
    @(posedge clk); #1;

    // Starts while busy must be ignored
    issue(3, 4, 0, 0, 1, "spur");
    @(posedge clk); #1;
    check("spur_one_done", done, 0);
    check("spur_no_requeue", busy, 0);

    // Zero operands take full latency and add nothing
    issue(0, 9, 0, 0, 0, "zero_mcand");
    @(posedge clk); #1;
    issue(200, 0, 0, 0, 0, "zero_mplier");
    @(posedge clk); #1;

    // Clear in the middle of RUN
    mcand = 8'd7; mplier = 8'd9; acc_clr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("midclr_busy", busy, 0);
    check("midclr_acc", acc, 0);
    check("midclr_ovf", ovf, 0);
    check("midclr_done", done, 0);
    m_acc = 0; m_ovf = 0;
    issue(7, 9, 0, 0, 0, "after_clr");
    @(posedge clk); #1;

    // Clear and start on the same edge
    mcand = 8'd9; mplier = 8'd9; acc_clr = 1'b1; start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    check("clr_prio_busy", busy, 0);
    check("clr_prio_acc", acc, 0);
    m_acc = 0; m_ovf = 0;
    repeat (12) @(posedge clk);
    #1;
    check("clr_prio_no_trace", acc, 0);

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      int a, b;
      bit c;
      a = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      c = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue(a, b, c, 0, 0, $sformatf("rnd%0d", i));
    end
    @(posedge clk); #1;

    // Overflow on the narrow accumulator
    issue_b(255, 255, 1, 65025, 0, "b_first");
    issue_b(255, 255, 0, 64514, 1, "b_wrap");
    issue_b(1, 1, 0, 64515, 1, "b_sticky");
    issue_b(1, 1, 1, 1, 0, "b_reclr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
